// File: rtl/vector_pkg.sv
// Shared types and constants for the vector display control path.
// Layer count and default beam-settle gap used by the frame scheduler.
package vector_pkg;

    localparam int N_LAYERS          = 4;
    localparam int SCHED_GAP_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ARM,
        RUN,
        GAP
    } sched_state_t;

endpackage

// File: rtl/vector_rr_arbiter.sv
// Circular priority find: first set req bit strictly after ptr, wrapping.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
// wrap flags a grant at or below ptr, i.e. the search went past the top index.
module vector_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             valid,
    output logic             wrap
);

    logic [SEL_W:0] idx;

    // Walk from the farthest candidate down so the nearest set bit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (SEL_W + 1)'(i + 1);
            if (idx >= (SEL_W + 1)'(N_SRC)) begin
                idx = idx - (SEL_W + 1)'(N_SRC);
            end
            if (req[idx[SEL_W-1:0]]) begin
                grant = idx[SEL_W-1:0];
                valid = 1'b1;
            end
        end
    end

    assign wrap = valid && (grant <= ptr);

endmodule

// File: rtl/vector_frame_scheduler.sv
// Round-robin frame scheduler for vector layers; runs go_master/halt per frame, then a settle gap.
// Latency: SELECT to go_master rise 2 cycles, halt to go_master fall 1 cycle. Backpressure: RUN holds until halt.
// Optional RUN watchdog enabled by defining VSCHED_WATCHDOG_EN.
module vector_frame_scheduler
    import vector_pkg::*;
#(
    parameter int N_SRC          = N_LAYERS,
    parameter int SEL_W          = $clog2(N_SRC),
    parameter int GAP_CYCLES     = SCHED_GAP_DEFAULT,
`ifdef VSCHED_WATCHDOG_EN
    parameter int TIMEOUT_CYCLES = 2**20,
`endif
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_SRC-1:0] layer_req,
    input  logic             halt,
    output logic             go_master,
    output logic [SEL_W-1:0] layer_sel,
    output logic             busy,
    output logic             frame_done,
    output logic             round_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             timeout_err
);

    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    sched_state_t     state;
    sched_state_t     post_state;
    logic [SEL_W-1:0] ptr;
    logic [GAP_W-1:0] gap_cnt;
    logic [SEL_W-1:0] arb_grant;
    logic             arb_vld;
    logic             arb_wrap;
    logic             wd_hit;

    vector_rr_arbiter #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_arb (
        .req   (layer_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_vld),
        .wrap  (arb_wrap)
    );

    // With no gap configured, a finished frame goes straight back to arbitration.
    assign post_state = (GAP_CYCLES == 0) ? (enable ? SELECT : IDLE) : GAP;

`ifdef VSCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt;

    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == RUN && !halt) begin
            wd_cnt <= wd_hit ? '0 : wd_cnt + WD_W'(1);
            if (wd_hit) begin
                timeout_err <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= SEL_W'(N_SRC - 1);
            gap_cnt    <= '0;
            go_master  <= 1'b0;
            layer_sel  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            round_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            round_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    go_master <= 1'b0;
                    if (enable && |layer_req) begin
                        state <= SELECT;
                        busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (arb_vld) begin
                        layer_sel  <= arb_grant;
                        ptr        <= arb_grant;
                        round_done <= arb_wrap;
                        state      <= ARM;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ARM: begin
                    state     <= RUN;
                    go_master <= 1'b1;
                end
                RUN: begin
                    // halt wins over a watchdog expiry in the same cycle
                    if (halt) begin
                        go_master  <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                        state      <= post_state;
                        busy       <= (post_state != IDLE);
                    end else if (wd_hit) begin
                        go_master <= 1'b0;
                        state     <= post_state;
                        busy      <= (post_state != IDLE);
                    end
                end
                GAP: begin
                    go_master <= 1'b0;
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        gap_cnt <= '0;
                        state   <= enable ? SELECT : IDLE;
                        busy    <= enable;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    go_master <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_frame_scheduler.sv
// Scoreboard bench for vector_frame_scheduler: grant order, gap timing, enable drop, reset, watchdog.
module tb_vector_frame_scheduler;

    typedef struct packed {
        logic [1:0] sel;
        logic       rd;
    } grant_exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  layer_req;
    logic        halt;
    logic        go_master;
    logic [1:0]  layer_sel;
    logic        busy;
    logic        frame_done;
    logic        round_done;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    logic        en0;
    logic [3:0]  req0;
    logic        halt0;
    logic        go0;
    logic [1:0]  sel0;
    logic        busy0;
    logic        fd0;
    logic        rd0;
    logic [15:0] cnt0;
    logic        to0;

    int vectors     = 0;
    int miscompares = 0;

    grant_exp_t  exp_q[$];
    logic [15:0] cnt_q[$];
    bit          go_prev;
    bit          rd_seen;

    vector_frame_scheduler #(
        .N_SRC          (4),
        .SEL_W          (2),
        .GAP_CYCLES     (16),
`ifdef VSCHED_WATCHDOG_EN
        .TIMEOUT_CYCLES (100),
`endif
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .layer_req   (layer_req),
        .halt        (halt),
        .go_master   (go_master),
        .layer_sel   (layer_sel),
        .busy        (busy),
        .frame_done  (frame_done),
        .round_done  (round_done),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    vector_frame_scheduler #(
        .N_SRC      (4),
        .SEL_W      (2),
        .GAP_CYCLES (0),
        .CNT_W      (16)
    ) dut0 (
        .clk         (clk),
        .rst         (rst),
        .enable      (en0),
        .layer_req   (req0),
        .halt        (halt0),
        .go_master   (go0),
        .layer_sel   (sel0),
        .busy        (busy0),
        .frame_done  (fd0),
        .round_done  (rd0),
        .frame_cnt   (cnt0),
        .timeout_err (to0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wait_rise(input bit z, output int n);
        n = 0;
        while ((z ? go0 : go_master) !== 1'b1) begin
            if (n >= 400) begin
                vectors++;
                miscompares++;
                $display("FAIL go_rise_timeout: got no rise in %0d cycles, want a rise", n);
                return;
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_halt(input bit z);
        if (z) halt0 = 1'b1; else halt = 1'b1;
        @(negedge clk);
        if (z) halt0 = 1'b0; else halt = 1'b0;
        check("halt_to_go_fall", z ? go0 : go_master, 0);
    endtask

    task automatic do_frame(input bit z, input int hold, input int exp_gap);
        int n;
        wait_rise(z, n);
        check("go_rise_gap", n, exp_gap);
        repeat (hold) @(negedge clk);
        pulse_halt(z);
    endtask

    task automatic push_grant(input logic [1:0] sel, input logic rd);
        grant_exp_t e;
        e.sel = sel;
        e.rd  = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each go_master rise against the next expected grant, each frame_done against frame_cnt.
    initial begin
        grant_exp_t e;
        go_prev = 1'b0;
        rd_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                go_prev = 1'b0;
                rd_seen = 1'b0;
            end else begin
                if (round_done) rd_seen = 1'b1;
                if (go_master && !go_prev) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_grant: got layer_sel %0d, want no frame", layer_sel);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_sel", layer_sel, e.sel);
                        check("grant_round_done", rd_seen, e.rd);
                    end
                    rd_seen = 1'b0;
                end
                if (frame_done) begin
                    if (cnt_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame_done: got frame_cnt %0d, want no frame_done", frame_cnt);
                    end else begin
                        check("frame_cnt", frame_cnt, cnt_q.pop_front());
                    end
                end
                go_prev = go_master;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0; enable = 1'b0; layer_req = 4'b0000; halt = 1'b0;
        en0 = 1'b0; req0 = 4'b0001; halt0 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_go", go_master, 0);
        check("rst_sel", layer_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_round_done", round_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Rotation over layers 0,1,3 with 16-cycle gaps.
        push_grant(2'd0, 1'b1); push_grant(2'd1, 1'b0); push_grant(2'd3, 1'b0);
        push_grant(2'd0, 1'b1); push_grant(2'd1, 1'b0); push_grant(2'd3, 1'b0);
        for (int i = 1; i <= 6; i++) cnt_q.push_back(16'(i));
        layer_req = 4'b1011;
        enable    = 1'b1;
        do_frame(1'b0, 50, 3);
        for (int i = 0; i < 5; i++) do_frame(1'b0, 50, 18);
        check("cnt_after_6", frame_cnt, 6);

        // Enable dropped mid-RUN: frame finishes, gap runs, then idle.
        push_grant(2'd0, 1'b1);
        cnt_q.push_back(16'd7);
        wait_rise(1'b0, n);
        check("gap_before_7", n, 18);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        pulse_halt(1'b0);
        check("drop_frame_done", frame_done, 1);
        repeat (15) @(negedge clk);
        check("drop_busy_in_gap", busy, 1);
        @(negedge clk);
        check("drop_busy_after_gap", busy, 0);
        repeat (40) @(negedge clk);
        check("drop_go_stays_low", go_master, 0);

        // Reset mid-RUN at frame_cnt 3, then first grant is layer 0 again.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        push_grant(2'd0, 1'b1); push_grant(2'd1, 1'b0); push_grant(2'd3, 1'b0); push_grant(2'd0, 1'b1);
        for (int i = 1; i <= 3; i++) cnt_q.push_back(16'(i));
        enable = 1'b1;
        do_frame(1'b0, 50, 3);
        do_frame(1'b0, 50, 18);
        do_frame(1'b0, 50, 18);
        wait_rise(1'b0, n);
        repeat (10) @(negedge clk);
        check("pre_rst_frame_cnt", frame_cnt, 3);
        #2 rst = 1'b0;
        #1;
        check("async_rst_go", go_master, 0);
        check("async_rst_sel", layer_sel, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_frame_cnt", frame_cnt, 0);
        check("async_rst_frame_done", frame_done, 0);
        check("async_rst_round_done", round_done, 0);
        @(negedge clk);
        push_grant(2'd0, 1'b1);
        cnt_q.push_back(16'd1);
        rst = 1'b1;
        wait_rise(1'b0, n);
        check("post_rst_rise", n, 3);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        pulse_halt(1'b0);
        repeat (25) @(negedge clk);

        // No requests while enabled: stays idle. Then a single layer regrants with round_done.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        layer_req = 4'b0000;
        enable    = 1'b1;
        repeat (10) @(negedge clk);
        check("noreq_go", go_master, 0);
        check("noreq_busy", busy, 0);
        push_grant(2'd2, 1'b1); push_grant(2'd2, 1'b1);
        cnt_q.push_back(16'd1); cnt_q.push_back(16'd2);
        layer_req = 4'b0100;
        do_frame(1'b0, 20, 3);
        wait_rise(1'b0, n);
        check("single_gap", n, 18);
        layer_req = 4'b0000;
        repeat (20) @(negedge clk);
        check("sel_held_after_req_drop", layer_sel, 2);
        enable = 1'b0;
        pulse_halt(1'b0);
        check("req_drop_frame_cnt", frame_cnt, 2);
        repeat (25) @(negedge clk);

        // Zero-gap instance: halt to next go rise is 2 cycles.
        en0 = 1'b1;
        do_frame(1'b1, 10, 3);
        do_frame(1'b1, 10, 2);
        wait_rise(1'b1, n);
        check("gap0_rise", n, 2);
        repeat (10) @(negedge clk);
        en0 = 1'b0;
        pulse_halt(1'b1);
        repeat (10) @(negedge clk);
        check("gap0_frame_cnt", cnt0, 3);
        check("gap0_go_idle", go0, 0);
        check("gap0_busy_idle", busy0, 0);

`ifdef VSCHED_WATCHDOG_EN
        // Watchdog: no halt, RUN ends after 100 cycles with the sticky flag.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        layer_req = 4'b0001;
        push_grant(2'd0, 1'b1);
        enable = 1'b1;
        wait_rise(1'b0, n);
        check("wd_rise", n, 3);
        enable = 1'b0;
        n = 0;
        while (go_master && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("wd_run_len", n, 100);
        check("wd_timeout_set", timeout_err, 1);
        check("wd_frame_cnt", frame_cnt, 0);
        repeat (30) @(negedge clk);
        check("wd_timeout_sticky", timeout_err, 1);
        check("wd_busy_idle", busy, 0);
`else
        check("no_wd_timeout", timeout_err, 0);
`endif

        check("grant_queue_drained", exp_q.size(), 0);
        check("cnt_queue_drained", cnt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
